pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 165 ++++++++++++++++
 tb/tb_pc_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Fetch program-counter unit with delay-slot control transfers,
//             a one-entry redirect buffer for stalled fetch, and
//             exception / eret redirection.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             fetch_stall         - hold the fetch PC
//             d_valid, pc_D       - ID-stage transfer valid / ID-stage PC
//             npc_sel, br_op      - transfer kind / branch condition
//             rs_val, rt_val      - forwarded register operands
//             imm26               - jump index; [15:0] is the branch offset
//             exc_req, eret, epc  - exception entry / return and return PC
//             pc_F, pc4_F         - fetch PC (registered) and fetch PC + 4
//             taken               - ID-stage transfer resolved taken
//             pend                - a redirect target is buffered
//             misalign            - a misaligned jr target was just loaded
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_stall,
    input  logic        d_valid,
    input  logic [31:0] pc_D,
    input  logic [2:0]  npc_sel,
    input  logic [2:0]  br_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [25:0] imm26,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_F,
    output logic [31:0] pc4_F,
    output logic        taken,
    output logic        pend,
    output logic        misalign
);

    localparam logic [2:0] c_SEL_BR  = 3'b001;
    localparam logic [2:0] c_SEL_J   = 3'b010;
    localparam logic [2:0] c_SEL_JR  = 3'b011;

    localparam logic [2:0] c_BR_BEQ  = 3'b000;
    localparam logic [2:0] c_BR_BNE  = 3'b001;
    localparam logic [2:0] c_BR_BLEZ = 3'b010;
    localparam logic [2:0] c_BR_BGTZ = 3'b011;
    localparam logic [2:0] c_BR_BLTZ = 3'b100;
    localparam logic [2:0] c_BR_BGEZ = 3'b101;

    logic [31:0] r_pc_f;
    logic [31:0] r_pend_pc;
    logic        r_pend;
    logic        r_pend_mis;
    logic        r_misalign;

    logic [31:0] w_pc4_d;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_jr_target;
    logic        w_rs_neg;
    logic        w_rs_zero;
    logic        w_br_cond;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_target_mis;

    assign w_pc4_d     = pc_D + 32'd4;
    assign w_br_target = w_pc4_d + {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign w_j_target  = {w_pc4_d[31:28], imm26, 2'b00};
    assign w_jr_target = {rs_val[31:2], 2'b00};

    // Signed compares against zero reduce to the sign bit and a zero test.
    assign w_rs_neg  = rs_val[31];
    assign w_rs_zero = (rs_val == 32'd0);

    always_comb begin
        w_br_cond = 1'b0;
        case (br_op)
            c_BR_BEQ:  w_br_cond = (rs_val == rt_val);
            c_BR_BNE:  w_br_cond = (rs_val != rt_val);
            c_BR_BLEZ: w_br_cond = w_rs_neg | w_rs_zero;
            c_BR_BGTZ: w_br_cond = ~w_rs_neg & ~w_rs_zero;
            c_BR_BLTZ: w_br_cond = w_rs_neg;
            c_BR_BGEZ: w_br_cond = ~w_rs_neg;
            default:   w_br_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_taken      = 1'b0;
        w_target     = w_br_target;
        w_target_mis = 1'b0;
        if (d_valid) begin
            case (npc_sel)
                c_SEL_BR: begin
                    w_taken  = w_br_cond;
                    w_target = w_br_target;
                end
                c_SEL_J: begin
                    w_taken  = 1'b1;
                    w_target = w_j_target;
                end
                c_SEL_JR: begin
                    w_taken      = 1'b1;
                    w_target     = w_jr_target;
                    w_target_mis = (rs_val[1:0] != 2'b00);
                end
                default: w_taken = 1'b0;
            endcase
        end
    end

    // Priority: reset > exc_req > eret > taken > pend > fetch_stall > sequential.
    // The misalign flag travels with a buffered target so it is raised on the
    // edge that actually loads that target into pc_F.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f     <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_pc  <= 32'd0;
            r_pend_mis <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (exc_req) begin
                r_pc_f <= EXC_PC;
                r_pend <= 1'b0;
            end else if (eret) begin
                r_pc_f <= epc;
                r_pend <= 1'b0;
            end else if (w_taken) begin
                if (!fetch_stall) begin
                    r_pc_f     <= w_target;
                    r_pend     <= 1'b0;
                    r_misalign <= w_target_mis;
                end else begin
                    r_pend_pc  <= w_target;
                    r_pend_mis <= w_target_mis;
                    r_pend     <= 1'b1;
                end
            end else if (r_pend) begin
                if (!fetch_stall) begin
                    r_pc_f     <= r_pend_pc;
                    r_pend     <= 1'b0;
                    r_misalign <= r_pend_mis;
                end
            end else if (!fetch_stall) begin
                r_pc_f <= r_pc_f + 32'd4;
            end
        end
    end

    assign pc_F     = r_pc_f;
    assign pc4_F    = r_pc_f + 32'd4;
    assign taken    = w_taken;
    assign pend     = r_pend;
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Self-checking bench for pc_unit: directed scenarios followed by
//             randomized cycles compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        fetch_stall;
    logic        d_valid;
    logic [31:0] pc_D;
    logic [2:0]  npc_sel;
    logic [2:0]  br_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [25:0] imm26;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc_F;
    logic [31:0] pc4_F;
    logic        taken;
    logic        pend;
    logic        misalign;

    pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_stall (fetch_stall),
        .d_valid     (d_valid),
        .pc_D        (pc_D),
        .npc_sel     (npc_sel),
        .br_op       (br_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .imm26       (imm26),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .pc_F        (pc_F),
        .pc4_F       (pc4_F),
        .taken       (taken),
        .pend        (pend),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_pend_mis;
    bit          m_mis;
    bit          m_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Resolve the ID-stage transfer straight from the instruction semantics.
    task automatic ref_xfer(output bit tk, output logic [31:0] tgt, output bit mis);
        int rs_s, rt_s, off;
        rs_s = $signed(rs_val);
        rt_s = $signed(rt_val);
        off  = $signed(imm26[15:0]);
        tk = 1'b0; tgt = 32'd0; mis = 1'b0;
        if (d_valid) begin
            if (npc_sel == 3'd1) begin
                case (br_op)
                    3'd0: tk = (rs_s == rt_s);
                    3'd1: tk = (rs_s != rt_s);
                    3'd2: tk = (rs_s <= 0);
                    3'd3: tk = (rs_s > 0);
                    3'd4: tk = (rs_s < 0);
                    3'd5: tk = (rs_s >= 0);
                    default: tk = 1'b0;
                endcase
                tgt = pc_D + 32'd4 + 32'(off * 4);
            end else if (npc_sel == 3'd2) begin
                tk  = 1'b1;
                tgt = ((pc_D + 32'd4) & 32'hF000_0000) | (32'(imm26) * 32'd4);
            end else if (npc_sel == 3'd3) begin
                tk  = 1'b1;
                tgt = rs_val - (rs_val % 4);
                mis = (rs_val % 4) != 0;
            end
        end
    endtask

    task automatic idle();
        reset = 0; fetch_stall = 0; d_valid = 0; pc_D = 32'd0; npc_sel = 3'd0;
        br_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; imm26 = 26'd0;
        exc_req = 0; eret = 0; epc = 32'd0;
    endtask

    // Inputs are already applied; check combinational outputs, take one edge,
    // advance the model and check the registered outputs.
    task automatic step();
        bit tk, mis;
        logic [31:0] tgt;
        ref_xfer(tk, tgt, mis);
        #1;
        chk("taken", {31'd0, taken}, {31'd0, tk});
        if (m_known) chk("pc4_F", pc4_F, m_pc + 32'd4);
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0000_3000; m_pend = 0; m_pend_pc = 0; m_pend_mis = 0; m_mis = 0;
            m_known = 1'b1;
        end else begin
            m_mis = 0;
            if (exc_req) begin
                m_pc = 32'h0000_4180; m_pend = 0;
            end else if (eret) begin
                m_pc = epc; m_pend = 0;
            end else if (tk && !fetch_stall) begin
                m_pc = tgt; m_pend = 0; m_mis = mis;
            end else if (tk) begin
                m_pend_pc = tgt; m_pend_mis = mis; m_pend = 1;
            end else if (m_pend && !fetch_stall) begin
                m_pc = m_pend_pc; m_pend = 0; m_mis = m_pend_mis;
            end else if (!m_pend && !fetch_stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        if (m_known) begin
            chk("pc_F", pc_F, m_pc);
            chk("pend", {31'd0, pend}, {31'd0, m_pend});
            chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
        end
    endtask

    initial begin
        idle();

        // Reset then three free cycles
        reset = 1; step(); chk("rst_pc", pc_F, 32'h3000);
        chk("rst_pend", {31'd0, pend}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        idle(); step(); chk("seq1", pc_F, 32'h3004);
        step(); chk("seq2", pc_F, 32'h3008);
        step(); chk("seq3", pc_F, 32'h300C);

        // Branch beq forward / backward / not taken
        idle(); d_valid = 1; pc_D = 32'h3000; npc_sel = 3'd1; br_op = 3'd0;
        rs_val = 5; rt_val = 5; imm26 = 26'h0001;
        step(); chk("beq_fwd", pc_F, 32'h3008);
        imm26 = 26'h0FFFF; step(); chk("beq_back", pc_F, 32'h3000);
        rt_val = 6; step(); chk("beq_nt", pc_F, 32'h3004);

        // Jump and misaligned jr
        idle(); d_valid = 1; pc_D = 32'h3000; npc_sel = 3'd2; imm26 = 26'h233;
        step(); chk("j", pc_F, 32'h0000_08CC);
        npc_sel = 3'd3; rs_val = 32'h0000_3011;
        step(); chk("jr", pc_F, 32'h3010); chk("jr_mis", {31'd0, misalign}, 32'd1);
        idle(); step(); chk("mis_pulse", {31'd0, misalign}, 32'd0);

        // Stalled bgtz buffered, then released
        idle(); fetch_stall = 1; d_valid = 1; pc_D = 32'h3000; npc_sel = 3'd1;
        br_op = 3'd3; rs_val = 1; imm26 = 26'h003F;
        step(); chk("stall_pend", {31'd0, pend}, 32'd1);
        d_valid = 0; step(); chk("stall_hold", {31'd0, pend}, 32'd1);
        fetch_stall = 0; step(); chk("pend_load", pc_F, 32'h3100);
        chk("pend_clr", {31'd0, pend}, 32'd0);

        // Exception beats taken branch and pend; then eret
        fetch_stall = 1; d_valid = 1; step();
        exc_req = 1; step(); chk("exc_pc", pc_F, 32'h4180);
        chk("exc_pend", {31'd0, pend}, 32'd0);
        idle(); eret = 1; epc = 32'h3200; fetch_stall = 1;
        step(); chk("eret", pc_F, 32'h3200);

        // Wrap through FFFF_FFFC, then reset while pend is set
        idle(); d_valid = 1; npc_sel = 3'd3; rs_val = 32'hFFFF_FFFC; step();
        idle(); step(); chk("wrap", pc_F, 32'h0);
        fetch_stall = 1; d_valid = 1; npc_sel = 3'd2; step();
        reset = 1; step(); chk("rst_pend_pc", pc_F, 32'h3000);
        chk("rst_pend_clr", {31'd0, pend}, 32'd0);

        // Randomized cycles
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            exc_req     = ($urandom_range(0, 19) == 0);
            eret        = ($urandom_range(0, 19) == 0);
            epc         = $urandom & 32'hFFFF_FFFC;
            fetch_stall = ($urandom_range(0, 2) == 0);
            d_valid     = ($urandom_range(0, 3) != 0);
            pc_D        = ($urandom_range(0, 1) == 0) ? m_pc - 32'd4 : $urandom;
            npc_sel     = 3'($urandom_range(0, 7));
            br_op       = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: rs_val = 32'd0;
                1: rs_val = 32'd1;
                2: rs_val = 32'hFFFF_FFFF;
                3: rs_val = 32'h8000_0000;
                default: rs_val = $urandom;
            endcase
            rt_val = ($urandom_range(0, 1) == 0) ? rs_val : $urandom;
            imm26  = 26'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
